lsu_mem_master: RTL

- Load/store initiator that sits between the core's execute stage and the word-addressed data memory.
- Accepts one byte, halfword or word load/store request per transaction over a valid/ready handshake, and drives the memory's address, write-enable and write-data inputs.
- Implements sub-word stores as read-modify-write, because the memory has only a whole-word write enable.
- Returns sign- or zero-extended load data, plus an error flag for misaligned, out-of-range or illegal requests.

---
 rtl/lsu_mem_master.sv | 176 +++++++++++++++++
 1 files changed

// File: rtl/lsu_mem_master.sv
// lsu_mem_master: load/store initiator between the core execute stage and a
// word-addressed data memory that has only a whole-word write enable.
//
// Request side  : req_valid_i/req_ready_o handshake carrying store flag,
//                 RV32I funct3, byte address and store data.
// Response side: resp_valid_o/resp_ready_i handshake carrying extended load
//                 data and an error flag (misaligned, out of range, illegal).
// Memory side   : mem_address_o (word index), mem_write_enable_o,
//                 mem_write_data_o, and a combinational mem_read_data_i.
//
// Sub-word stores are performed as read-modify-write. Every output is a
// register, so the memory sees a stable address for the whole cycle in
// which its read data is consumed.
module lsu_mem_master #(
    parameter int MEM_DEPTH = 64,
    parameter int IDX_W     = 6
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic        req_store_i,
    input  logic [2:0]  req_funct3_i,
    input  logic [31:0] req_addr_i,
    input  logic [31:0] req_wdata_i,
    output logic        resp_valid_o,
    input  logic        resp_ready_i,
    output logic [31:0] resp_rdata_o,
    output logic        resp_error_o,
    output logic [31:0] mem_address_o,
    output logic        mem_write_enable_o,
    output logic [31:0] mem_write_data_o,
    input  logic [31:0] mem_read_data_i
);

    localparam logic [29:0] DEPTH_WORDS = 30'(MEM_DEPTH);

    // DECODE is the cycle in which the latched request is checked, which is
    // what gives an error response its one-cycle latency.
    typedef enum logic [2:0] {
        S_IDLE,
        S_DECODE,
        S_READ,
        S_RMW_READ,
        S_WRITE,
        S_RESP
    } state_e;

    state_e      state_q;
    logic        store_q;
    logic [2:0]  funct3_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;

    logic        req_err;
    logic [31:0] shifted;
    logic [31:0] load_ext;
    logic [31:0] merged;

    always_comb begin
        // NOTE: every variable written here gets a default first, so no path
        // leaves one unassigned and no latch is inferred.
        req_err  = 1'b0;
        shifted  = mem_read_data_i >> {addr_q[1:0], 3'b000};
        load_ext = mem_read_data_i;
        merged   = mem_read_data_i;

        if (store_q) begin
            if (!(funct3_q inside {3'b000, 3'b001, 3'b010})) req_err = 1'b1;
        end else begin
            if (!(funct3_q inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101})) req_err = 1'b1;
        end
        if (funct3_q[1:0] == 2'b01 && addr_q[0])          req_err = 1'b1;
        if (funct3_q[1:0] == 2'b10 && addr_q[1:0] != 2'b00) req_err = 1'b1;
        if (addr_q[31:2] >= DEPTH_WORDS)                  req_err = 1'b1;

        unique case (funct3_q)
            3'b000:  load_ext = {{24{shifted[7]}},  shifted[7:0]};
            3'b001:  load_ext = {{16{shifted[15]}}, shifted[15:0]};
            3'b100:  load_ext = {24'b0, shifted[7:0]};
            3'b101:  load_ext = {16'b0, shifted[15:0]};
            default: load_ext = mem_read_data_i;
        endcase

        // Unselected lanes keep the word just read from memory.
        if (funct3_q[1:0] == 2'b00) begin
            merged[{addr_q[1:0], 3'b000} +: 8] = wdata_q[7:0];
        end else begin
            merged[{addr_q[1], 4'b0000} +: 16] = wdata_q[15:0];
        end
    end

    // NOTE: sequential state is updated with non-blocking assignments only,
    // so every register samples the values from before this edge.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q            <= S_IDLE;
            store_q            <= 1'b0;
            funct3_q           <= 3'b000;
            addr_q             <= 32'b0;
            wdata_q            <= 32'b0;
            req_ready_o        <= 1'b1;
            resp_valid_o       <= 1'b0;
            resp_rdata_o       <= 32'b0;
            resp_error_o       <= 1'b0;
            mem_address_o      <= 32'b0;
            mem_write_enable_o <= 1'b0;
            mem_write_data_o   <= 32'b0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (req_valid_i) begin
                        store_q     <= req_store_i;
                        funct3_q    <= req_funct3_i;
                        addr_q      <= req_addr_i;
                        wdata_q     <= req_wdata_i;
                        req_ready_o <= 1'b0;
                        state_q     <= S_DECODE;
                    end
                end
                S_DECODE: begin
                    if (req_err) begin
                        resp_valid_o <= 1'b1;
                        resp_error_o <= 1'b1;
                        resp_rdata_o <= 32'b0;
                        state_q      <= S_RESP;
                    end else begin
                        mem_address_o <= {{(32-IDX_W){1'b0}}, addr_q[IDX_W+1:2]};
                        if (!store_q) begin
                            state_q <= S_READ;
                        end else if (funct3_q == 3'b010) begin
                            mem_write_enable_o <= 1'b1;
                            mem_write_data_o   <= wdata_q;
                            state_q            <= S_WRITE;
                        end else begin
                            state_q <= S_RMW_READ;
                        end
                    end
                end
                S_READ: begin
                    resp_rdata_o <= load_ext;
                    resp_error_o <= 1'b0;
                    resp_valid_o <= 1'b1;
                    state_q      <= S_RESP;
                end
                S_RMW_READ: begin
                    mem_write_enable_o <= 1'b1;
                    mem_write_data_o   <= merged;
                    state_q            <= S_WRITE;
                end
                S_WRITE: begin
                    mem_write_enable_o <= 1'b0;
                    resp_rdata_o       <= 32'b0;
                    resp_error_o       <= 1'b0;
                    resp_valid_o       <= 1'b1;
                    state_q            <= S_RESP;
                end
                S_RESP: begin
                    // Nothing touches memory here, however long the core stalls.
                    if (resp_ready_i) begin
                        resp_valid_o <= 1'b0;
                        resp_error_o <= 1'b0;
                        resp_rdata_o <= 32'b0;
                        req_ready_o  <= 1'b1;
                        state_q      <= S_IDLE;
                    end
                end
                default: begin
                    state_q     <= S_IDLE;
                    req_ready_o <= 1'b1;
                end
            endcase
        end
    end

endmodule
